// File: rtl/full_logic_param.sv
// Transmit-layer full logic: main FIFO -> NUM_VC virtual-channel FIFOs -> NUM_D destination
// FIFOs. It provides round-robin VC arbitration, almost-full threshold backpressure per stage,
// a pause output, per-destination underflow flags, and an init/idle/active/error control FSM.
module full_logic_param #(
    parameter int unsigned DATA_W = 6,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned NUM_VC = 2,
    parameter int unsigned NUM_D  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic                    wr_enable,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [ADDR_W:0]         umbral_MF,
    input  logic [ADDR_W:0]         umbral_VC,
    input  logic [ADDR_W:0]         umbral_D,
    input  logic [NUM_D-1:0]        pop,
    output logic [NUM_D*DATA_W-1:0] data_out,
    output logic [NUM_D-1:0]        empty_d,
    output logic [NUM_D-1:0]        error_d,
    output logic                    pause_out,
    output logic                    idle_out,
    output logic                    active_out,
    output logic                    error_out
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned VC_B  = $clog2(NUM_VC);
    localparam int unsigned D_B   = $clog2(NUM_D);

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W:0]   cnt_t;
    typedef logic [ADDR_W-1:0] ptr_t;
    typedef logic [VC_B-1:0]   vc_idx_t;
    typedef logic [D_B-1:0]    d_idx_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

    typedef enum logic [1:0] {StInit, StIdle, StActive, StError} state_t;

    // A threshold of zero or above the FIFO depth means "no early backpressure".
    function automatic cnt_t sat_th(input cnt_t t);
        return ((t == '0) || (t > DEPTH_C)) ? DEPTH_C : t;
    endfunction

    state_t  state_q;
    cnt_t    th_mf_q, th_vc_q, th_d_q;
    vc_idx_t rr_q;

    word_t   mf_mem [DEPTH];
    ptr_t    mf_rd_q, mf_wr_q;
    cnt_t    mf_cnt_q;

    word_t   vc_mem [NUM_VC][DEPTH];
    ptr_t    vc_rd_q [NUM_VC];
    ptr_t    vc_wr_q [NUM_VC];
    cnt_t    vc_cnt_q [NUM_VC];

    word_t   d_mem [NUM_D][DEPTH];
    ptr_t    d_rd_q [NUM_D];
    ptr_t    d_wr_q [NUM_D];
    cnt_t    d_cnt_q [NUM_D];
    word_t   d_out_q [NUM_D];
    logic [NUM_D-1:0] error_d_q;

    logic              xfer_en, overflow, mf_push, mf_pop, err_evt, all_empty;
    word_t             mf_head;
    vc_idx_t           s1_vc;
    word_t             vc_head [NUM_VC];
    d_idx_t            vc_dst [NUM_VC];
    logic [NUM_VC-1:0] s2_elig, vc_push, vc_pop;
    logic              s2_valid;
    vc_idx_t           s2_vc, cand;
    d_idx_t            s2_dst;
    word_t             s2_word;
    logic [NUM_D-1:0]  d_push, d_pop_ok, underflow;

    // Stage 1 decode: main FIFO head and whether its VC has room below threshold.
    always_comb begin
        xfer_en  = (state_q == StIdle) || (state_q == StActive);
        // Overflow uses the registered count, so a same-cycle read does not save the word.
        overflow = wr_enable && (mf_cnt_q == DEPTH_C);
        mf_push  = wr_enable && xfer_en && !overflow;
        mf_head  = mf_mem[mf_rd_q];
        s1_vc    = mf_head[DATA_W-1 -: VC_B];
        mf_pop   = xfer_en && (mf_cnt_q != '0) && (vc_cnt_q[s1_vc] < th_vc_q);
    end

    // Stage 2 eligibility: VC non-empty and its head's destination below threshold.
    always_comb begin
        s2_elig = '0;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            vc_head[v]  = vc_mem[v][vc_rd_q[v]];
            vc_dst[v]   = vc_head[v][DATA_W-1-VC_B -: D_B];
            s2_elig[v]  = (vc_cnt_q[v] != '0) && (d_cnt_q[vc_dst[v]] < th_d_q);
        end
    end

    // Round-robin grant: first eligible VC after the last granted one.
    always_comb begin
        s2_valid = 1'b0;
        s2_vc    = '0;
        cand     = '0;
        for (int k = 1; k <= int'(NUM_VC); k++) begin
            cand = rr_q + vc_idx_t'(k);
            if (!s2_valid && s2_elig[cand]) begin
                s2_valid = 1'b1;
                s2_vc    = cand;
            end
        end
        s2_valid = s2_valid && xfer_en;
        s2_dst   = vc_dst[s2_vc];
        s2_word  = vc_head[s2_vc];
    end

    // Per-FIFO push/pop strobes and the global error/empty summaries.
    always_comb begin
        for (int v = 0; v < int'(NUM_VC); v++) begin
            vc_push[v] = mf_pop && (s1_vc == vc_idx_t'(v));
            vc_pop[v]  = s2_valid && (s2_vc == vc_idx_t'(v));
        end
        all_empty = (mf_cnt_q == '0);
        for (int v = 0; v < int'(NUM_VC); v++) begin
            all_empty = all_empty && (vc_cnt_q[v] == '0);
        end
        for (int i = 0; i < int'(NUM_D); i++) begin
            d_push[i]    = s2_valid && (s2_dst == d_idx_t'(i));
            d_pop_ok[i]  = pop[i] && (d_cnt_q[i] != '0);
            underflow[i] = pop[i] && (d_cnt_q[i] == '0);
            all_empty    = all_empty && (d_cnt_q[i] == '0);
        end
        err_evt = overflow || (|underflow);
    end

    // Control FSM, threshold capture and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StInit;
            th_mf_q <= DEPTH_C;
            th_vc_q <= DEPTH_C;
            th_d_q  <= DEPTH_C;
            rr_q    <= vc_idx_t'(NUM_VC - 1);
        end else begin
            if ((state_q == StInit) && init) begin
                th_mf_q <= sat_th(umbral_MF);
                th_vc_q <= sat_th(umbral_VC);
                th_d_q  <= sat_th(umbral_D);
            end
            if (s2_valid) begin
                rr_q <= s2_vc;
            end
            if (err_evt) begin
                state_q <= StError;
            end else begin
                case (state_q)
                    StInit:   if (!init) state_q <= StIdle;
                    StIdle: begin
                        if (init) begin
                            state_q <= StInit;
                        end else if (!all_empty) begin
                            state_q <= StActive;
                        end
                    end
                    StActive: if (all_empty) state_q <= StIdle;
                    default:  state_q <= StError;
                endcase
            end
        end
    end

    // Main FIFO storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mf_rd_q  <= '0;
            mf_wr_q  <= '0;
            mf_cnt_q <= '0;
        end else begin
            if (mf_push) begin
                mf_mem[mf_wr_q] <= data_in;
                mf_wr_q         <= mf_wr_q + ptr_t'(1);
            end
            if (mf_pop) begin
                mf_rd_q <= mf_rd_q + ptr_t'(1);
            end
            mf_cnt_q <= mf_cnt_q + cnt_t'(mf_push) - cnt_t'(mf_pop);
        end
    end

    // VC FIFO storage.
    always_ff @(posedge clk) begin
        for (int v = 0; v < int'(NUM_VC); v++) begin
            if (!reset) begin
                vc_rd_q[v]  <= '0;
                vc_wr_q[v]  <= '0;
                vc_cnt_q[v] <= '0;
            end else begin
                if (vc_push[v]) begin
                    vc_mem[v][vc_wr_q[v]] <= mf_head;
                    vc_wr_q[v]            <= vc_wr_q[v] + ptr_t'(1);
                end
                if (vc_pop[v]) begin
                    vc_rd_q[v] <= vc_rd_q[v] + ptr_t'(1);
                end
                vc_cnt_q[v] <= vc_cnt_q[v] + cnt_t'(vc_push[v]) - cnt_t'(vc_pop[v]);
            end
        end
    end

    // Destination FIFO storage, registered read data and underflow pulses.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NUM_D); i++) begin
            if (!reset) begin
                d_rd_q[i]    <= '0;
                d_wr_q[i]    <= '0;
                d_cnt_q[i]   <= '0;
                d_out_q[i]   <= '0;
                error_d_q[i] <= 1'b0;
            end else begin
                if (d_push[i]) begin
                    d_mem[i][d_wr_q[i]] <= s2_word;
                    d_wr_q[i]           <= d_wr_q[i] + ptr_t'(1);
                end
                if (d_pop_ok[i]) begin
                    d_out_q[i] <= d_mem[i][d_rd_q[i]];
                    d_rd_q[i]  <= d_rd_q[i] + ptr_t'(1);
                end
                d_cnt_q[i]   <= d_cnt_q[i] + cnt_t'(d_push[i]) - cnt_t'(d_pop_ok[i]);
                error_d_q[i] <= underflow[i];
            end
        end
    end

    // Output packing and state decode.
    always_comb begin
        data_out = '0;
        empty_d  = '0;
        for (int i = 0; i < int'(NUM_D); i++) begin
            data_out[i*DATA_W +: DATA_W] = d_out_q[i];
            empty_d[i]                   = (d_cnt_q[i] == '0);
        end
        error_d    = error_d_q;
        pause_out  = (mf_cnt_q >= th_mf_q);
        idle_out   = (state_q == StIdle);
        active_out = (state_q == StActive);
        error_out  = (state_q == StError);
    end

endmodule
